regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-side initiator for the 32x32 register file's single write port (address/data/write-enable). It merges in-order results from the main pipeline with out-of-order results from long-latency units (mul/div, cache-miss loads) through a small FIFO, and drives one registered write per cycle. It also keeps a per-register pending-write scoreboard for the hazard unit and publishes the committed write for forwarding.

## Interface
- DATA_W, 32, data width of results and of the register-file write data
- ADDR_W, 5, register address width; the scoreboard has 2**ADDR_W entries
- FIFO_DEPTH, 2, long-latency result buffer depth; must be a power of two and at least 2

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- p_valid  in  1  main-pipe result valid; no backpressure, must always be accepted
- p_addr  in  ADDR_W  main-pipe destination register
- p_data  in  DATA_W  main-pipe result
- m_valid  in  1  long-latency result valid
- m_ready  out  1  FIFO can accept a result; equals !full
- m_addr  in  ADDR_W  long-latency destination register
- m_data  in  DATA_W  long-latency result
- sb_set  in  1  a long-latency op has been issued; mark its destination pending
- sb_set_addr  in  ADDR_W  destination of the issued op
- sb_busy  out  2**ADDR_W  pending-write vector; bit 0 is always 0
- err_sb  out  1  sticky error flag, cleared only by reset
- wb_we  out  1  register-file write enable (registered)
- wb_addr  out  ADDR_W  register-file write address (registered)
- wb_data  out  DATA_W  register-file write data (registered)
- fwd_valid, fwd_addr, fwd_data  out  1/ADDR_W/DATA_W  copy of the write committing this cycle

## Operation
- Reset (asynchronous assert):
  - FIFO empty, sb_busy=0, err_sb=0.
  - wb_we/wb_addr/wb_data=0 and fwd_*=0.
  - m_ready=1, since the FIFO is not full.
- FIFO accepts on m_valid && m_ready. Pointers wrap modulo FIFO_DEPTH. Occupancy counter is ADDR-independent and sized log2(FIFO_DEPTH)+1 bits.
- Arbitration, each cycle:
  - If p_valid: main pipe wins. The write is registered, and the FIFO head is held.
  - Else if the FIFO is non-empty: pop the head and register it as the write.
  - Else: wb_we=0 next cycle.
- No fairness guarantee. The hazard unit must stall issue on sb_busy to bound FIFO starvation.
- Register 0: any write with address 0 (either source) produces wb_we=0.
  - A FIFO entry for r0 is still popped, taking its arbitration slot.
  - wb_addr/wb_data still update.
- Simultaneous push and pop on a full FIFO: push is refused, because m_ready is already 0 that cycle. Push and pop in the same cycle with count 1 keeps count at 1.
- Scoreboard:
  - sb_set with addr!=0 sets the bit on the next edge.
  - The bit clears on the edge where a FIFO-sourced write to that address is registered.
  - Main-pipe writes never clear bits.
  - Set and clear of the same bit in the same cycle: set wins.
  - sb_set to an already-busy register, or sb_set to r0, is ignored for state but sets err_sb.

## Timing
- Main pipe: p_valid sampled at edge N gives wb_we=1 from edge N to edge N+1. Latency is 1.
- Long-latency result: accepted at edge N, earliest wb_we at edge N+1 when p_valid is low in cycle N+1. Minimum latency is 1, with no bypass around the FIFO. The FIFO is a true registered buffer; the head is visible the cycle after the push.
- m_ready is combinational from registered occupancy only. It has no combinational path from m_valid or p_valid.
- sb_busy is registered, and the clear is visible the same edge wb_we asserts. The register file captures on that same edge, so the hazard unit must use fwd_* for one cycle.
- Asynchronous reset mid-operation discards FIFO contents and pending scoreboard bits. No partial write is emitted after deassertion.

## Configuration
- WB_FWD_EN defined: fwd_valid/fwd_addr/fwd_data are registered copies of wb_we/wb_addr/wb_data and update on the same edge.
- WB_FWD_EN undefined: the forwarding registers are not built, and fwd_* are tied to 0. The hazard unit must then stall one extra cycle after an sb_busy clear.

## Test plan
- Reset check: assert rst=0 mid-cycle -> wb_we=0, sb_busy=0, err_sb=0, m_ready=1 immediately.
- Main-pipe write: p_valid=1, p_addr=7, p_data=0xDEADBEEF at edge N -> wb_we=1, wb_addr=7, wb_data=0xDEADBEEF after N. With WB_FWD_EN, fwd_* match.
- Scoreboard round-trip:
  - sb_set addr=9 -> sb_busy[9]=1 next edge.
  - Then m result addr=9, data=0x1234 with p idle -> wb_we with addr 9 one cycle after acceptance; sb_busy[9]=0 on that same edge.
- Collision and fill:
  - Hold p_valid=1 for 4 cycles while m_valid=1 (addrs 3, 4, 5) -> FIFO takes 3 and 4, then m_ready=0, and 5 is not accepted.
  - After p_valid drops, writes 3 then 4 then 5 appear on consecutive cycles.
- r0 and errors:
  - p_addr=0 and a FIFO entry with addr 0 -> wb_we stays 0 and the FIFO count decrements.
  - sb_set on busy reg 12 -> err_sb=1 and stays 1 until reset.
- Same-cycle set/clear: FIFO write to reg 6 retires while sb_set addr=6 -> sb_busy[6]=1 after the edge.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if
//   Bundles the result, scoreboard, register-file write and forwarding
//   signals of the write-back arbiter.
//   slave  : arbiter view (takes results and sb_set, drives m_ready, sb_busy,
//            err_sb, wb_*, fwd_*)
//   master : environment view (pipeline, long-latency units, hazard unit,
//            register file)
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                   p_valid;
  logic [ADDR_W-1:0]      p_addr;
  logic [DATA_W-1:0]      p_data;
  logic                   m_valid;
  logic                   m_ready;
  logic [ADDR_W-1:0]      m_addr;
  logic [DATA_W-1:0]      m_data;
  logic                   sb_set;
  logic [ADDR_W-1:0]      sb_set_addr;
  logic [2**ADDR_W-1:0]   sb_busy;
  logic                   err_sb;
  logic                   wb_we;
  logic [ADDR_W-1:0]      wb_addr;
  logic [DATA_W-1:0]      wb_data;
  logic                   fwd_valid;
  logic [ADDR_W-1:0]      fwd_addr;
  logic [DATA_W-1:0]      fwd_data;

  modport slave (
    input  p_valid, p_addr, p_data,
    input  m_valid, m_addr, m_data,
    output m_ready,
    input  sb_set, sb_set_addr,
    output sb_busy, err_sb,
    output wb_we, wb_addr, wb_data,
    output fwd_valid, fwd_addr, fwd_data
  );

  modport master (
    output p_valid, p_addr, p_data,
    output m_valid, m_addr, m_data,
    input  m_ready,
    output sb_set, sb_set_addr,
    input  sb_busy, err_sb,
    input  wb_we, wb_addr, wb_data,
    input  fwd_valid, fwd_addr, fwd_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Write-side initiator for the register file's single write port. Main
//   pipeline results always win; long-latency results wait in a small FIFO
//   and drain when the pipe is idle. Keeps a pending-write scoreboard and a
//   sticky scoreboard error flag.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous, active-low reset
//   bus  - regfile_wb_arbiter_if.slave (results, scoreboard, wb_*, fwd_*)
// Configuration macro:
//   WB_FWD_EN - when defined, fwd_* are registered copies of wb_*;
//               otherwise fwd_* are tied to 0.
module regfile_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2
) (
  input logic                  clk,
  input logic                  rst,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int NREG  = 2**ADDR_W;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  // Long-latency result buffer
  logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;

  // Write port and scoreboard state
  logic              r_wb_we;
  logic [ADDR_W-1:0] r_wb_addr;
  logic [DATA_W-1:0] r_wb_data;
  logic [NREG-1:0]   r_sb_busy;
  logic              r_err_sb;

  logic              w_we_next;
  logic [ADDR_W-1:0] w_addr_next;
  logic [DATA_W-1:0] w_data_next;
  logic [NREG-1:0]   w_set_vec;
  logic [NREG-1:0]   w_clr_vec;
  logic              w_clr_hit;
  logic              w_set_legal;
  logic              w_sb_err;

  assign w_full      = (r_count == FULL_CNT);
  assign w_empty     = (r_count == '0);
  assign w_push      = bus.m_valid && !w_full;
  // The FIFO only drains in cycles the main pipe leaves free.
  assign w_pop       = !bus.p_valid && !w_empty;
  assign w_head_addr = r_fifo_addr[r_rd_ptr];
  assign w_head_data = r_fifo_data[r_rd_ptr];

  assign bus.m_ready = !w_full;

  // Write select. Address 0 still occupies the slot and updates addr/data,
  // but never enables the write. Idle cycles hold addr/data.
  always_comb begin
    w_we_next   = 1'b0;
    w_addr_next = r_wb_addr;
    w_data_next = r_wb_data;
    if (bus.p_valid) begin
      w_we_next   = (bus.p_addr != '0);
      w_addr_next = bus.p_addr;
      w_data_next = bus.p_data;
    end else if (w_pop) begin
      w_we_next   = (w_head_addr != '0);
      w_addr_next = w_head_addr;
      w_data_next = w_head_data;
    end
  end

  // A register retiring from the FIFO this cycle may be re-issued in the
  // same cycle: that is a legal set (set wins), not a double issue.
  assign w_clr_hit   = w_pop && (w_head_addr == bus.sb_set_addr);
  assign w_set_legal = bus.sb_set && (bus.sb_set_addr != '0) &&
                       (!r_sb_busy[bus.sb_set_addr] || w_clr_hit);
  assign w_sb_err    = bus.sb_set && !w_set_legal;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_sb
      if (gi == 0) begin : g_r0
        assign w_set_vec[gi] = 1'b0;
        assign w_clr_vec[gi] = 1'b0;
      end else begin : g_rn
        assign w_set_vec[gi] = w_set_legal && (bus.sb_set_addr == ADDR_W'(gi));
        assign w_clr_vec[gi] = w_pop && (w_head_addr == ADDR_W'(gi));
      end
    end
  endgenerate

  // FIFO storage has no reset; validity is carried by the count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= bus.m_addr;
      r_fifo_data[r_wr_ptr] <= bus.m_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_wb_we   <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
      r_sb_busy <= '0;
      r_err_sb  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
      r_wb_we   <= w_we_next;
      r_wb_addr <= w_addr_next;
      r_wb_data <= w_data_next;
      r_sb_busy <= (r_sb_busy & ~w_clr_vec) | w_set_vec;
      r_err_sb  <= r_err_sb | w_sb_err;
    end
  end

  assign bus.wb_we   = r_wb_we;
  assign bus.wb_addr = r_wb_addr;
  assign bus.wb_data = r_wb_data;
  assign bus.sb_busy = r_sb_busy;
  assign bus.err_sb  = r_err_sb;

`ifdef WB_FWD_EN
  logic              r_fwd_valid;
  logic [ADDR_W-1:0] r_fwd_addr;
  logic [DATA_W-1:0] r_fwd_data;

  // Loaded from the same next-state as wb_*, so it mirrors the write that
  // the register file is capturing this cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fwd_valid <= 1'b0;
      r_fwd_addr  <= '0;
      r_fwd_data  <= '0;
    end else begin
      r_fwd_valid <= w_we_next;
      r_fwd_addr  <= w_addr_next;
      r_fwd_data  <= w_data_next;
    end
  end

  assign bus.fwd_valid = r_fwd_valid;
  assign bus.fwd_addr  = r_fwd_addr;
  assign bus.fwd_data  = r_fwd_data;
`else
  assign bus.fwd_valid = 1'b0;
  assign bus.fwd_addr  = '0;
  assign bus.fwd_data  = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//   Table-driven vectors, hand sequences for multi-cycle corners, and a
//   randomized run, all checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 5;
  localparam int FIFO_DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_wb_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  string tag = "";

  // Reference model state
  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;
  ent_t        q[$];
  logic [31:0] mdl_busy;
  logic        mdl_err;
  logic        mdl_we;
  logic [4:0]  mdl_addr;
  logic [31:0] mdl_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s %s: got %0h expected %0h", tag, name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mdl_busy = '0;
    mdl_err  = 1'b0;
    mdl_we   = 1'b0;
    mdl_addr = '0;
    mdl_data = '0;
  endtask

  // One clock of the behaviour: pipe wins, else oldest buffered result
  // drains; a result is buffered if there was room at the start of the cycle.
  task automatic model_step();
    ent_t        h;
    logic        popped;
    int          sz0;
    logic [31:0] nb;
    sz0    = q.size();
    popped = 1'b0;
    h      = '0;
    nb     = mdl_busy;
    if (bus.p_valid) begin
      mdl_we   = (bus.p_addr != 0);
      mdl_addr = bus.p_addr;
      mdl_data = bus.p_data;
    end else if (sz0 > 0) begin
      h        = q.pop_front();
      popped   = 1'b1;
      mdl_we   = (h.addr != 0);
      mdl_addr = h.addr;
      mdl_data = h.data;
      nb[h.addr] = 1'b0;
    end else begin
      mdl_we = 1'b0;
    end
    if (bus.m_valid && sz0 < FIFO_DEPTH) q.push_back({bus.m_addr, bus.m_data});
    if (bus.sb_set) begin
      if (bus.sb_set_addr == 0 ||
          (mdl_busy[bus.sb_set_addr] && !(popped && h.addr == bus.sb_set_addr)))
        mdl_err = 1'b1;
      else
        nb[bus.sb_set_addr] = 1'b1;
    end
    nb[0]    = 1'b0;
    mdl_busy = nb;
  endtask

  task automatic compare_all();
    chk("wb_we",   64'(bus.wb_we),   64'(mdl_we));
    chk("wb_addr", 64'(bus.wb_addr), 64'(mdl_addr));
    chk("wb_data", 64'(bus.wb_data), 64'(mdl_data));
    chk("m_ready", 64'(bus.m_ready), 64'(q.size() < FIFO_DEPTH));
    chk("sb_busy", 64'(bus.sb_busy), 64'(mdl_busy));
    chk("err_sb",  64'(bus.err_sb),  64'(mdl_err));
`ifdef WB_FWD_EN
    chk("fwd_valid", 64'(bus.fwd_valid), 64'(mdl_we));
    chk("fwd_addr",  64'(bus.fwd_addr),  64'(mdl_addr));
    chk("fwd_data",  64'(bus.fwd_data),  64'(mdl_data));
`else
    chk("fwd_valid", 64'(bus.fwd_valid), 64'd0);
    chk("fwd_addr",  64'(bus.fwd_addr),  64'd0);
    chk("fwd_data",  64'(bus.fwd_data),  64'd0);
`endif
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    bus.p_valid = 1'b0; bus.p_addr = '0; bus.p_data = '0;
    bus.m_valid = 1'b0; bus.m_addr = '0; bus.m_data = '0;
    bus.sb_set  = 1'b0; bus.sb_set_addr = '0;
  endtask

  typedef struct {
    logic        pv;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic        ewe;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic        erdy;
  } vec_t;
  vec_t tbl[9];

  initial begin
    // Main-pipe write, then collision-and-fill: FIFO takes 3 and 4, refuses 5
    // while full, then drains 3,4,5 on consecutive cycles once p_valid drops.
    tbl[0] = '{1'b1, 5'd7,  32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b1, 5'd7,  32'hDEADBEEF, 1'b1};
    tbl[1] = '{1'b1, 5'd1,  32'h11,       1'b1, 5'd3, 32'h33, 1'b1, 5'd1,  32'h11,       1'b1};
    tbl[2] = '{1'b1, 5'd2,  32'h22,       1'b1, 5'd4, 32'h44, 1'b1, 5'd2,  32'h22,       1'b0};
    tbl[3] = '{1'b1, 5'd8,  32'h88,       1'b1, 5'd5, 32'h55, 1'b1, 5'd8,  32'h88,       1'b0};
    tbl[4] = '{1'b1, 5'd10, 32'hAA,       1'b1, 5'd5, 32'h55, 1'b1, 5'd10, 32'hAA,       1'b0};
    tbl[5] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5, 32'h55, 1'b1, 5'd3,  32'h33,       1'b1};
    tbl[6] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5, 32'h55, 1'b1, 5'd4,  32'h44,       1'b1};
    tbl[7] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd5,  32'h55,       1'b1};
    tbl[8] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd5,  32'h55,       1'b1};

    idle();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    tag = "reset";
    compare_all();

    for (int i = 0; i < 9; i++) begin
      tag = $sformatf("vec%0d", i);
      bus.p_valid = tbl[i].pv; bus.p_addr = tbl[i].pa; bus.p_data = tbl[i].pd;
      bus.m_valid = tbl[i].mv; bus.m_addr = tbl[i].ma; bus.m_data = tbl[i].md;
      step();
      chk("tbl_we",    64'(bus.wb_we),   64'(tbl[i].ewe));
      chk("tbl_addr",  64'(bus.wb_addr), 64'(tbl[i].ea));
      chk("tbl_data",  64'(bus.wb_data), 64'(tbl[i].ed));
      chk("tbl_ready", 64'(bus.m_ready), 64'(tbl[i].erdy));
    end

    // Scoreboard round-trip on r9
    tag = "sb9";
    idle(); bus.sb_set = 1'b1; bus.sb_set_addr = 5'd9;
    step();
    chk("busy9_set", 64'(bus.sb_busy[9]), 64'd1);
    idle(); bus.m_valid = 1'b1; bus.m_addr = 5'd9; bus.m_data = 32'h1234;
    step();
    chk("no_bypass_we", 64'(bus.wb_we), 64'd0);
    idle();
    step();
    chk("sb9_we",    64'(bus.wb_we),      64'd1);
    chk("sb9_addr",  64'(bus.wb_addr),    64'd9);
    chk("sb9_data",  64'(bus.wb_data),    64'h1234);
    chk("busy9_clr", 64'(bus.sb_busy[9]), 64'd0);

    // r0 from both sources: no write enable, FIFO entry still consumed
    tag = "r0";
    idle(); bus.p_valid = 1'b1; bus.p_data = 32'h5A5A;
    bus.m_valid = 1'b1; bus.m_addr = 5'd0; bus.m_data = 32'hC0;
    step();
    chk("p_r0_we",   64'(bus.wb_we),   64'd0);
    chk("p_r0_data", 64'(bus.wb_data), 64'h5A5A);
    bus.m_addr = 5'd11; bus.m_data = 32'hB;
    step();
    chk("r0_full", 64'(bus.m_ready), 64'd0);
    idle();
    step();
    chk("m_r0_we",    64'(bus.wb_we),   64'd0);
    chk("m_r0_data",  64'(bus.wb_data), 64'hC0);
    chk("m_r0_ready", 64'(bus.m_ready), 64'd1);
    step();
    chk("after_r0_addr", 64'(bus.wb_addr), 64'd11);
    step();

    // Double issue of r12 sets the sticky error
    tag = "err";
    bus.sb_set = 1'b1; bus.sb_set_addr = 5'd12;
    step();
    step();
    chk("err_set", 64'(bus.err_sb), 64'd1);
    idle();
    repeat (3) step();
    chk("err_sticky", 64'(bus.err_sb), 64'd1);

    // Same-cycle retire and re-issue of r6: set wins
    tag = "setclr";
    bus.sb_set = 1'b1; bus.sb_set_addr = 5'd6;
    step();
    idle(); bus.m_valid = 1'b1; bus.m_addr = 5'd6; bus.m_data = 32'h66;
    step();
    idle(); bus.sb_set = 1'b1; bus.sb_set_addr = 5'd6;
    step();
    chk("setclr_we",   64'(bus.wb_we),      64'd1);
    chk("setclr_busy", 64'(bus.sb_busy[6]), 64'd1);

    // Asynchronous reset mid-cycle with a full FIFO and pending bits
    tag = "midrst";
    idle(); bus.p_valid = 1'b1; bus.p_addr = 5'd2; bus.p_data = 32'h2;
    bus.m_valid = 1'b1; bus.m_addr = 5'd13; bus.m_data = 32'hD;
    step();
    step();
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    chk("rst_we",    64'(bus.wb_we),   64'd0);
    chk("rst_busy",  64'(bus.sb_busy), 64'd0);
    chk("rst_err",   64'(bus.err_sb),  64'd0);
    chk("rst_ready", 64'(bus.m_ready), 64'd1);
    idle();
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("post_rst_we", 64'(bus.wb_we), 64'd0);
    step();

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      tag = $sformatf("rnd%0d", c);
      bus.p_valid     = ($urandom_range(0, 9) < 4);
      bus.p_addr      = 5'($urandom_range(0, 31));
      bus.p_data      = $urandom;
      bus.m_valid     = ($urandom_range(0, 1) == 1);
      bus.m_addr      = 5'($urandom_range(0, 31));
      bus.m_data      = $urandom;
      bus.sb_set      = ($urandom_range(0, 4) == 0);
      bus.sb_set_addr = 5'($urandom_range(0, 31));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
